// File: rtl/mio_arb_pkg.sv
// mio_arb_pkg: state encoding and grant codes shared by the arbiter files
package mio_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA, DONE} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU = 2'b01;
  localparam logic [1:0] GNT_DMA = 2'b10;
endpackage

// File: rtl/mio_arbiter_if.sv
// mio_arbiter_if: request/complete handshake between a requester (master) and a responder (slave)
interface mio_arbiter_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mio_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, pick=1 selects requester 1 (DMA)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick
);
  assign pick = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/mio_arbiter.sv
// mio_arbiter: round-robin CPU/DMA arbiter for a shared memory/IO bus with ack timeout
module mio_arbiter
  import mio_arb_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mio_arbiter_if.slave         cpu,
  mio_arbiter_if.slave         dma,
  mio_arbiter_if.master        bus,
  output logic                 timeout,
  output logic [1:0]           grant
);
  state_t state;
  logic last;
  logic pick;
  logic own;
  logic expired;
  logic [7:0] cnt;
  logic [31:0] cpu_rd, dma_rd;
  logic to_q;
  rr_pick2 u_pick (.req({dma.req, cpu.req}), .last(last), .pick(pick));
  assign own = state == OWN_CPU || state == OWN_DMA;
  assign expired = cnt == 8'(MAX_WAIT - 1);
  // last doubles as the current owner from entry into OWN_x through DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      cpu_rd <= '0;
      dma_rd <= '0;
      to_q <= 1'b0;
    end else if (state == IDLE) begin
      if (cpu.req || dma.req) begin
        state <= pick ? OWN_DMA : OWN_CPU;
        last <= pick;
        cnt <= '0;
      end
    end else if (own) begin
      if (bus.ack || expired) begin
        state <= DONE;
        to_q <= ~bus.ack;
        if (last) dma_rd <= bus.ack ? bus.rdata : '0;
        else cpu_rd <= bus.ack ? bus.rdata : '0;
      end else cnt <= cnt + 8'd1;
    end else begin
      state <= IDLE;
      to_q <= 1'b0;
    end
  end
  always_comb begin
    bus.req = own;
    bus.we = own & (last ? dma.we : cpu.we);
    bus.addr = own ? (last ? dma.addr : cpu.addr) : '0;
    bus.wdata = own ? (last ? dma.wdata : cpu.wdata) : '0;
    cpu.ack = state == DONE && !last;
    dma.ack = state == DONE && last;
    cpu.rdata = cpu_rd;
    dma.rdata = dma_rd;
    timeout = to_q;
    grant = state == IDLE ? GNT_NONE : (last ? GNT_DMA : GNT_CPU);
  end
endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed checks of arbitration, latency, timeout and reset behaviour
module tb_mio_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic timeout;
  logic [1:0] grant;
  int tests = 0;
  int fails = 0;
  int n;
  mio_arbiter_if cpu ();
  mio_arbiter_if dma ();
  mio_arbiter_if bus ();
  mio_arbiter #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .cpu(cpu), .dma(dma), .bus(bus),
    .timeout(timeout), .grant(grant)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    cpu.req = 0; cpu.we = 0; cpu.addr = 0; cpu.wdata = 0;
    dma.req = 0; dma.we = 0; dma.addr = 0; dma.wdata = 0;
    bus.ack = 0; bus.rdata = 0;
    tick;
    tick;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_bus_req", 32'(bus.req), 32'h0);
    chk("rst_cpu_ready", 32'(cpu.ack), 32'h0);
    chk("rst_dma_ready", 32'(dma.ack), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_cpu_rdata", cpu.rdata, 32'h0);
    reset = 1;
    // CPU read
    cpu.req = 1; cpu.addr = 32'h0000_0010;
    tick;
    chk("rd_bus_req", 32'(bus.req), 32'h1);
    chk("rd_bus_addr", bus.addr, 32'h0000_0010);
    chk("rd_bus_we", 32'(bus.we), 32'h0);
    chk("rd_grant", 32'(grant), 32'h1);
    tick;
    chk("rd_wait_ready", 32'(cpu.ack), 32'h0);
    bus.ack = 1; bus.rdata = 32'hCAFE_0001;
    tick;
    chk("rd_cpu_ready", 32'(cpu.ack), 32'h1);
    chk("rd_cpu_rdata", cpu.rdata, 32'hCAFE_0001);
    chk("rd_dma_ready", 32'(dma.ack), 32'h0);
    chk("rd_timeout", 32'(timeout), 32'h0);
    chk("rd_done_bus_req", 32'(bus.req), 32'h0);
    chk("rd_done_grant", 32'(grant), 32'h1);
    bus.ack = 0; cpu.req = 0;
    tick;
    chk("rd_idle_grant", 32'(grant), 32'h0);
    chk("rd_idle_ready", 32'(cpu.ack), 32'h0);
    // stray ack while idle
    bus.ack = 1; bus.rdata = 32'hDEAD_BEEF;
    tick;
    chk("stray_cpu_ready", 32'(cpu.ack), 32'h0);
    chk("stray_dma_ready", 32'(dma.ack), 32'h0);
    chk("stray_cpu_rdata", cpu.rdata, 32'hCAFE_0001);
    chk("stray_dma_rdata", dma.rdata, 32'h0);
    chk("stray_grant", 32'(grant), 32'h0);
    bus.ack = 0;
    // DMA write
    dma.req = 1; dma.we = 1; dma.addr = 32'hE000_0000; dma.wdata = 32'h1234_5678;
    tick;
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_bus_req", 32'(bus.req), 32'h1);
    chk("wr_bus_we", 32'(bus.we), 32'h1);
    chk("wr_bus_addr", bus.addr, 32'hE000_0000);
    chk("wr_bus_wdata", bus.wdata, 32'h1234_5678);
    bus.ack = 1; bus.rdata = 32'h0000_00AA;
    tick;
    chk("wr_dma_ready", 32'(dma.ack), 32'h1);
    chk("wr_cpu_ready", 32'(cpu.ack), 32'h0);
    chk("wr_bus_we_off", 32'(bus.we), 32'h0);
    bus.ack = 0; dma.req = 0; dma.we = 0;
    tick;
    chk("wr_idle_ready", 32'(dma.ack), 32'h0);
    // tie from reset: CPU, DMA, CPU
    reset = 0;
    tick;
    reset = 1;
    chk("tie_rst_cpu_rdata", cpu.rdata, 32'h0);
    chk("tie_rst_dma_rdata", dma.rdata, 32'h0);
    cpu.req = 1; dma.req = 1;
    tick;
    chk("tie_g1", 32'(grant), 32'h1);
    bus.ack = 1; bus.rdata = 32'h0000_0001;
    tick;
    chk("tie_cpu_ready1", 32'(cpu.ack), 32'h1);
    bus.ack = 0;
    tick;
    chk("tie_idle1", 32'(grant), 32'h0);
    tick;
    chk("tie_g2", 32'(grant), 32'h2);
    bus.ack = 1; bus.rdata = 32'h0000_0002;
    tick;
    chk("tie_dma_ready", 32'(dma.ack), 32'h1);
    chk("tie_dma_rdata", dma.rdata, 32'h0000_0002);
    chk("tie_cpu_rdata_hold", cpu.rdata, 32'h0000_0001);
    bus.ack = 0;
    tick;
    tick;
    chk("tie_g3", 32'(grant), 32'h1);
    bus.ack = 1; bus.rdata = 32'h0000_0003;
    tick;
    chk("tie_cpu_ready3", 32'(cpu.ack), 32'h1);
    bus.ack = 0; cpu.req = 0; dma.req = 0;
    tick;
    // timeout, requester drops req mid-transaction
    cpu.req = 1; cpu.addr = 32'h0000_0020;
    tick;
    cpu.req = 0;
    n = 0;
    for (int i = 0; i < 40 && bus.req; i++) begin
      n++;
      tick;
    end
    chk("to_bus_req_cycles", 32'(n), 32'd16);
    chk("to_cpu_ready", 32'(cpu.ack), 32'h1);
    chk("to_timeout", 32'(timeout), 32'h1);
    chk("to_cpu_rdata", cpu.rdata, 32'h0);
    tick;
    chk("to_idle_timeout", 32'(timeout), 32'h0);
    chk("to_idle_grant", 32'(grant), 32'h0);
    // reset in the third OWN_DMA cycle
    dma.req = 1;
    tick;
    chk("rm_grant", 32'(grant), 32'h2);
    tick;
    tick;
    reset = 0;
    tick;
    chk("rm_bus_req", 32'(bus.req), 32'h0);
    chk("rm_grant_none", 32'(grant), 32'h0);
    chk("rm_dma_ready", 32'(dma.ack), 32'h0);
    reset = 1; cpu.req = 1;
    tick;
    chk("rm_tie_cpu", 32'(grant), 32'h1);
    chk("rm_dma_ready2", 32'(dma.ack), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
